// File: rtl/alu_pkg.sv
// Shared types and constants for the registered ALU stage.
// Opcode encoding, FSM state encoding and the data width used across the slice.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   // Codes 11-15 are reserved and are not named here.
   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_NOTA  = 4'd5,
      OP_SLL   = 4'd6,
      OP_SRL   = 4'd7,
      OP_ADC   = 4'd8,
      OP_PASSB = 4'd9,
      OP_CMP   = 4'd10
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      SHIFT = 2'd2,
      FIN   = 2'd3
   } alu_state_t;

   function automatic logic isShift(input alu_op_t op);
      return (op == OP_SLL) || (op == OP_SRL);
   endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Operand/opcode/handshake bundle between the source muxes and the ALU stage.
// The ALU uses the slave modport; the upstream driver uses master.
interface alu_unit_if;
   import alu_pkg::*;

   logic [ALU_WIDTH-1:0] ALUInputA;
   logic [ALU_WIDTH-1:0] ALUInputB;
   logic [3:0]           ALUOp;
   logic                 Start;
   logic                 FlagWrite;
   logic [ALU_WIDTH-1:0] Result;
   logic                 Zero;
   logic                 Carry;
   logic                 Negative;
   logic                 Busy;
   logic                 Done;

   modport master (
      output ALUInputA, ALUInputB, ALUOp, Start, FlagWrite,
      input  Result, Zero, Carry, Negative, Busy, Done
   );

   modport slave (
      input  ALUInputA, ALUInputB, ALUOp, Start, FlagWrite,
      output Result, Zero, Carry, Negative, Busy, Done
   );
endinterface

// File: rtl/alu_core.sv
// Combinational datapath for every single-cycle operation.
// Shift opcodes reaching here have amount 0 and simply pass A through.
module alu_core
   import alu_pkg::*;
(
   input  logic [ALU_WIDTH-1:0] opA,
   input  logic [ALU_WIDTH-1:0] opB,
   input  alu_op_t              op,
   input  logic                 carryIn,
   output logic [ALU_WIDTH-1:0] value,
   output logic                 carryOut
);

   logic [ALU_WIDTH:0] wide;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      wide     = '0;
      value    = '0;
      carryOut = 1'b0;
      unique case (op)
         OP_ADD, OP_ADC: begin
            wide     = {1'b0, opA} + {1'b0, opB} + {{ALU_WIDTH{1'b0}}, (op == OP_ADC) & carryIn};
            value    = wide[ALU_WIDTH-1:0];
            carryOut = wide[ALU_WIDTH];
         end
         OP_SUB, OP_CMP: begin
            // Bit 8 of the 9-bit difference is the borrow; Carry means "no borrow".
            wide     = {1'b0, opA} - {1'b0, opB};
            value    = wide[ALU_WIDTH-1:0];
            carryOut = ~wide[ALU_WIDTH];
         end
         OP_AND:         value = opA & opB;
         OP_OR:          value = opA | opB;
         OP_XOR:         value = opA ^ opB;
         OP_NOTA:        value = ~opA;
         OP_PASSB:       value = opB;
         OP_SLL, OP_SRL: value = opA;
         default:        value = '0;
      endcase
   end

endmodule

// File: rtl/alu_unit.sv
// Registered ALU stage: captures operands on Start, runs single-cycle ops via
// alu_core and shifts iteratively, one bit per cycle, under Busy/Done.
module alu_unit
   import alu_pkg::*;
(
   input  logic     CLK,
   input  logic     Reset,
   alu_unit_if.slave bus
);

   alu_state_t           state;
   logic [ALU_WIDTH-1:0] opA, opB, work, resultReg;
   alu_op_t              op;
   logic                 flagWr, shiftCarry;
   logic [2:0]           count;
   logic                 zeroReg, carryReg, negReg, busyReg, doneReg;
   logic [ALU_WIDTH-1:0] coreValue;
   logic                 coreCarry;

   alu_core core (
      .opA      (opA),
      .opB      (opB),
      .op       (op),
      .carryIn  (carryReg),
      .value    (coreValue),
      .carryOut (coreCarry)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         // NOTE: all state, including the shift working register and counter, is reset here.
         state      <= IDLE;
         opA        <= '0;
         opB        <= '0;
         op         <= OP_ADD;
         flagWr     <= 1'b0;
         work       <= '0;
         count      <= '0;
         shiftCarry <= 1'b0;
         resultReg  <= '0;
         zeroReg    <= 1'b0;
         carryReg   <= 1'b0;
         negReg     <= 1'b0;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.Start) begin
                  opA    <= bus.ALUInputA;
                  opB    <= bus.ALUInputB;
                  op     <= alu_op_t'(bus.ALUOp);
                  flagWr <= bus.FlagWrite;
                  if (isShift(alu_op_t'(bus.ALUOp)) && (bus.ALUInputB[2:0] != 3'd0)) begin
                     work       <= bus.ALUInputA;
                     count      <= bus.ALUInputB[2:0];
                     shiftCarry <= 1'b0;
                     busyReg    <= 1'b1;
                     state      <= SHIFT;
                  end else begin
                     state <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (op != OP_CMP) resultReg <= coreValue;
               if (flagWr) begin
                  zeroReg  <= (coreValue == '0);
                  negReg   <= coreValue[ALU_WIDTH-1];
                  carryReg <= coreCarry;
               end
               doneReg <= 1'b1;
               state   <= IDLE;
            end
            SHIFT: begin
               if (op == OP_SLL) {shiftCarry, work} <= {work, 1'b0};
               else              {work, shiftCarry} <= {1'b0, work};
               count <= count - 3'd1;
               if (count == 3'd1) begin
                  busyReg <= 1'b0;
                  state   <= FIN;
               end
            end
            FIN: begin
               resultReg <= work;
               if (flagWr) begin
                  zeroReg  <= (work == '0);
                  negReg   <= work[ALU_WIDTH-1];
                  carryReg <= shiftCarry;
               end
               doneReg <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Result   = resultReg;
   assign bus.Zero     = zeroReg;
   assign bus.Carry    = carryReg;
   assign bus.Negative = negReg;
   assign bus.Busy     = busyReg;
   assign bus.Done     = doneReg;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit with hand-computed expected values.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_alu_unit;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;

   alu_unit_if bus ();

   alu_unit dut (
      .CLK   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents an op and holds Start across exactly one rising edge (edge k).
   task automatic startOp(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b,
                          input logic fw);
      bus.ALUOp     = opc;
      bus.ALUInputA = a;
      bus.ALUInputB = b;
      bus.FlagWrite = fw;
      bus.Start     = 1'b1;
      step();
      bus.Start     = 1'b0;
   endtask

   initial begin
      bus.ALUInputA = '0;
      bus.ALUInputB = '0;
      bus.ALUOp     = '0;
      bus.Start     = 1'b0;
      bus.FlagWrite = 1'b0;

      // Reset state
      #12;
      check("rst_result", bus.Result, 8'h00);
      check("rst_flags", {bus.Zero, bus.Carry, bus.Negative}, 3'b000);
      check("rst_busy_done", {bus.Busy, bus.Done}, 2'b00);
      rst = 1'b0;
      step();

      // ADD 0xF0 + 0x20
      startOp(OP_ADD, 8'hF0, 8'h20, 1'b1);
      check("add_busy_low", bus.Busy, 1'b0);
      check("add_done_early", bus.Done, 1'b0);
      step();
      check("add_result", bus.Result, 8'h10);
      check("add_flags_zcn", {bus.Zero, bus.Carry, bus.Negative}, 3'b010);
      check("add_done", bus.Done, 1'b1);
      step();
      check("add_done_drop", bus.Done, 1'b0);

      // ADC 0x01 + 0x01 + carry(1)
      startOp(OP_ADC, 8'h01, 8'h01, 1'b1);
      step();
      check("adc_result", bus.Result, 8'h03);
      check("adc_flags_zcn", {bus.Zero, bus.Carry, bus.Negative}, 3'b000);
      step();

      // SUB 0x05 - 0x05
      startOp(OP_SUB, 8'h05, 8'h05, 1'b1);
      step();
      check("sub_result", bus.Result, 8'h00);
      check("sub_flags_zcn", {bus.Zero, bus.Carry, bus.Negative}, 3'b110);
      step();

      // CMP 0x03 vs 0x04: difference 0xFF, borrow, Result untouched
      startOp(OP_CMP, 8'h03, 8'h04, 1'b1);
      step();
      check("cmp_result_hold", bus.Result, 8'h00);
      check("cmp_flags_zcn", {bus.Zero, bus.Carry, bus.Negative}, 3'b001);
      check("cmp_done", bus.Done, 1'b1);
      step();

      // SLL 0x81 by 3 with an ADD pulsed during Busy
      startOp(OP_SLL, 8'h81, 8'h03, 1'b1);
      check("sll_busy_k", bus.Busy, 1'b1);
      bus.ALUOp     = OP_ADD;
      bus.ALUInputA = 8'h01;
      bus.ALUInputB = 8'h01;
      bus.Start     = 1'b1;
      step();
      bus.Start     = 1'b0;
      check("sll_busy_k1", bus.Busy, 1'b1);
      step();
      check("sll_busy_k2", {bus.Busy, bus.Done}, 2'b10);
      step();
      check("sll_busy_drop", {bus.Busy, bus.Done}, 2'b00);
      step();
      check("sll_done", bus.Done, 1'b1);
      check("sll_result", bus.Result, 8'h08);
      check("sll_flags_zcn", {bus.Zero, bus.Carry, bus.Negative}, 3'b000);
      step();
      check("sll_no_queued_op", {bus.Done, bus.Busy}, 2'b00);
      step();
      check("sll_result_kept", bus.Result, 8'h08);

      // SRL 0x81 by 1
      startOp(OP_SRL, 8'h81, 8'h01, 1'b1);
      check("srl1_busy_k", bus.Busy, 1'b1);
      step();
      check("srl1_busy_drop", bus.Busy, 1'b0);
      step();
      check("srl1_done", bus.Done, 1'b1);
      check("srl1_result", bus.Result, 8'h40);
      check("srl1_flags_zcn", {bus.Zero, bus.Carry, bus.Negative}, 3'b010);
      step();

      // AND without FlagWrite: Result 0x00 but flags keep Z0 C1 N0
      startOp(OP_AND, 8'hF0, 8'h0F, 1'b0);
      step();
      check("and_result", bus.Result, 8'h00);
      check("and_flags_hold", {bus.Zero, bus.Carry, bus.Negative}, 3'b010);
      step();

      // SRL by 0 (B = 0x08, low bits zero) takes the single-cycle path
      startOp(OP_SRL, 8'h7E, 8'h08, 1'b1);
      check("srl0_busy_k", bus.Busy, 1'b0);
      step();
      check("srl0_done", {bus.Done, bus.Busy}, 2'b10);
      check("srl0_result", bus.Result, 8'h7E);
      check("srl0_flags_zcn", {bus.Zero, bus.Carry, bus.Negative}, 3'b000);
      step();

      // Reserved opcode 11
      startOp(4'd11, 8'h05, 8'h05, 1'b1);
      step();
      check("rsv_result", bus.Result, 8'h00);
      check("rsv_flags_zcn", {bus.Zero, bus.Carry, bus.Negative}, 3'b100);
      check("rsv_done", bus.Done, 1'b1);
      step();

      // PASSB to make Result nonzero, then reset in the middle of a shift
      startOp(OP_PASSB, 8'h00, 8'hC3, 1'b1);
      step();
      check("passb_result", bus.Result, 8'hC3);
      check("passb_flags_zcn", {bus.Zero, bus.Carry, bus.Negative}, 3'b001);
      step();
      startOp(OP_SLL, 8'h55, 8'h05, 1'b1);
      step();
      step();
      check("midshift_busy", bus.Busy, 1'b1);
      rst = 1'b1;
      #1;
      check("async_rst_result", bus.Result, 8'h00);
      check("async_rst_flags", {bus.Zero, bus.Carry, bus.Negative}, 3'b000);
      check("async_rst_busy_done", {bus.Busy, bus.Done}, 2'b00);
      #2;
      rst = 1'b0;
      step();

      // ADD after reset behaves normally
      startOp(OP_ADD, 8'h12, 8'h34, 1'b1);
      check("post_rst_busy", bus.Busy, 1'b0);
      step();
      check("post_rst_result", bus.Result, 8'h46);
      check("post_rst_flags", {bus.Zero, bus.Carry, bus.Negative}, 3'b000);
      check("post_rst_done", bus.Done, 1'b1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_unit.md
# alu_unit

Registered 8-bit ALU stage sitting directly downstream of the ALU source-A and source-B muxes; it consumes `ALUInputA`/`ALUInputB` plus an opcode and produces a registered result and condition flags for write-back and branch logic. Single-cycle operations complete one clock after `Start`. Shifts run iteratively, one bit per cycle, under a Start/Busy/Done handshake. A flag register (Zero, Carry, Negative) holds state between instructions and feeds add-with-carry.

## Interface
- No parameters; data width fixed at 8.
- `CLK`  in  1  sole clock, rising edge
- `Reset`  in  1  asynchronous, active-high; clears all state
- `ALUInputA`  in  8  operand A, from the source-A mux
- `ALUInputB`  in  8  operand B, from the source-B mux
- `ALUOp`  in  4  opcode (`alu_op_t`)
- `Start`  in  1  launch operation; sampled only when not Busy
- `FlagWrite`  in  1  sampled with Start; 1 = update flags on completion
- `Result`  out  8  registered result
- `Zero`, `Carry`, `Negative`  out  1 each  registered flags
- `Busy`  out  1  high while a multi-cycle shift is in progress
- `Done`  out  1  one-cycle pulse when Result is updated

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOTA, 6 SLL, 7 SRL, 8 ADC, 9 PASSB, 10 CMP. Codes 11–15 are reserved.
- Arithmetic is 9 bits wide. ADD/ADC: Carry = bit 8 of A+B(+Carry). SUB/CMP: A-B, with Carry = 1 iff A ≥ B unsigned (no borrow).
- CMP updates only the flags (if FlagWrite); Result holds its previous value.
- Logic ops, NOTA and PASSB force Carry to 0.
- Reserved opcodes: Result = 0, Carry = 0, Done still pulses.
- Zero = (new Result == 0); for CMP, Zero = (A-B == 0). Negative = bit 7 of the same value.
- Flags change only when FlagWrite was 1 at Start.
- Shifts: amount = `ALUInputB[2:0]`. Shifts are logical, with zero fill. Carry = last bit shifted out. A shift amount of 0 behaves as single-cycle: Result = A, Carry = 0.
- Operands, opcode and FlagWrite are captured at Start. Input changes during Busy are ignored.
- FSM states:
  - IDLE: Start with a non-shift op, or a shift of 0 → EXEC. Start with a shift > 0 → SHIFT, loading the working register with A and the counter with the amount.
  - EXEC: write Result/flags, assert Done → IDLE.
  - SHIFT: shift one bit per cycle and decrement the counter. When the counter reaches 1 → FIN.
  - FIN: write Result/flags, assert Done → IDLE.
- Start while Busy is ignored (not queued).
- Reset, including mid-shift: state = IDLE; Result = 0; Zero = 0; Carry = 0; Negative = 0; Busy = 0; Done = 0; counter and working register = 0.

## Timing
- Start is sampled at edge k.
- Single-cycle op: Result, flags and Done are valid after edge k+1. Done drops after edge k+2.
- Shift by N (1–7): Busy rises after edge k and falls after edge k+N. Result and Done are valid after edge k+N+1.
- A new Start is accepted in the same cycle Done is high. Back-to-back single-cycle ops therefore run at 1 per 2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_t` (4-bit enum, values above)
  - `alu_state_t` (IDLE, EXEC, SHIFT, FIN)
  - `ALU_WIDTH = 8`
- Sub-module `alu_core` is purely combinational: it takes the captured operands, opcode and Carry, and returns the 8-bit value plus carry-out for single-cycle ops.
- `alu_unit` owns the FSM, shift datapath, counter and output/flag registers.

## Test plan
- Reset: assert Reset mid-shift (SLL, B = 5, after 2 cycles) → all outputs 0 asynchronously; state returns to IDLE; a following ADD works normally.
- ADD 0xF0 + 0x20, FlagWrite = 1 → Result 0x10, Carry 1, Zero 0, Negative 0. A following ADC 0x01 + 0x01 → Result 0x03.
- SUB 0x05 - 0x05, FlagWrite = 1 → Result 0x00, Zero 1, Carry 1. CMP 0x03 vs 0x04 → Result stays 0x00; Carry 0, Negative 1.
- SLL A = 0x81, B = 3 → Busy high for 3 cycles, Done one cycle later; Result 0x08, Carry 0. SRL A = 0x81, B = 1 → Result 0x40, Carry 1.
- Start pulsed during Busy with ADD → ignored; shift result unchanged. AND with FlagWrite = 0 → Result updates, flags hold.
- Shift amount 0 (SRL A = 0x7E) → single-cycle path: Result 0x7E, Busy never asserted, Done after edge k+1.
